// File: rtl/memory_access_stage_pkg.sv
// Shared definitions for the memory access stage: funct3 encodings, FSM states,
// access-width decode and the MEM/WB record layout.
package mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    W_BYTE = 2'd0,
    W_HALF = 2'd1,
    W_WORD = 2'd2
  } width_t;

  // Width comes from funct3[1:0] only; the spare codes 011/110/111 land on word.
  function automatic width_t access_width(input logic [2:0] f3);
    case (f3[1:0])
      F3_SB[1:0]: return W_BYTE;
      F3_SH[1:0]: return W_HALF;
      F3_SW[1:0]: return W_WORD;
      default:    return W_WORD;
    endcase
  endfunction

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] alu_out;
    logic [31:0] rd_data;
    logic [1:0]  wb_sel;
    logic [31:0] pc;
    logic        is_load;
  } memwb_t;

endpackage

// File: rtl/memory_access_stage_if.sv
// Data-memory request/response bus between the MEM stage (master) and memory (slave).
interface dmem_if;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [29:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic [31:0] dmem_rdata_i;
  logic        dmem_ack_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    input  dmem_rdata_i, dmem_ack_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    output dmem_rdata_i, dmem_ack_i
  );
endinterface

// File: rtl/load_store_aligner.sv
// Combinational lane logic: store byte enables and replication, load lane
// select with sign/zero extension, and alignment check.
module load_store_aligner
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  store_be,
  output logic [31:0] store_wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  width_t      width;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign width  = access_width(funct3);
  assign lane_b = load_word[{offset, 3'b000} +: 8];
  assign lane_h = offset[1] ? load_word[31:16] : load_word[15:0];

  always_comb begin
    store_be    = 4'b1111;
    store_wdata = store_data;
    misaligned  = 1'b0;
    case (width)
      W_BYTE: begin
        store_be    = 4'b0001 << offset;
        store_wdata = {4{store_data[7:0]}};
      end
      W_HALF: begin
        store_be    = 4'b0011 << {offset[1], 1'b0};
        store_wdata = {2{store_data[15:0]}};
        misaligned  = offset[0];
      end
      default: misaligned = (offset != 2'b00);
    endcase
  end

  always_comb begin
    case (funct3)
      F3_LB:   load_data = {{24{lane_b[7]}}, lane_b};
      F3_LBU:  load_data = {24'h0, lane_b};
      F3_LH:   load_data = {{16{lane_h[15]}}, lane_h};
      F3_LHU:  load_data = {16'h0, lane_h};
      F3_LW:   load_data = load_word;
      default: load_data = load_word;
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// MEM pipeline stage: IDLE/BUSY/DONE handshake with data memory and the MEM/WB register.
// Optional MEM_TIMEOUT_EN adds a BUSY-cycle watchdog that ends the access with bus_err_o.
module memory_access_stage
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] alu_out_i,
  input  logic [31:0] rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic [4:0]  rd_i,
  input  logic [1:0]  wb_sel_i,
  input  logic [31:0] pc_i,
  dmem_if.master      dmem,
  output logic        busywait_o,
  output logic [4:0]  rd_mem_wb_o,
  output logic [31:0] alu_out_mem_wb_o,
  output logic [31:0] rd_data_mem_wb_o,
  output logic [1:0]  wb_sel_mem_wb_o,
  output logic [31:0] pc_mem_wb_o,
  output logic        is_load_instr_mem_wb_o,
  output logic        misaligned_o,
  output logic        bus_err_o
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 1..255 (8-bit counter)");
  end

  state_t      state;
  logic [4:0]  rd_q;
  logic [31:0] alu_q;
  logic [1:0]  wb_sel_q;
  logic [31:0] pc_q;
  logic        is_load_q;
  logic [2:0]  f3_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  memwb_t      memwb_q;

  logic        mem_op, start, tmo_hit;
  logic [2:0]  al_f3;
  logic [1:0]  al_off;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_load;
  logic        al_misal;

  // In IDLE the aligner sees the live EX/MEM fields; afterwards the latched access.
  assign al_f3  = (state == ST_IDLE) ? funct3_i       : f3_q;
  assign al_off = (state == ST_IDLE) ? alu_out_i[1:0] : alu_q[1:0];

  load_store_aligner u_aligner (
    .funct3      (al_f3),
    .offset      (al_off),
    .store_data  (rs2_i),
    .load_word   (dmem.dmem_rdata_i),
    .store_be    (al_be),
    .store_wdata (al_wdata),
    .load_data   (al_load),
    .misaligned  (al_misal)
  );

  assign mem_op     = is_load_i | is_store_i;
  assign start      = (state == ST_IDLE) && mem_op && !al_misal;
  assign busywait_o = start || (state == ST_BUSY);

  assign dmem.dmem_req_o   = (state == ST_BUSY);
  assign dmem.dmem_we_o    = we_q;
  assign dmem.dmem_addr_o  = alu_q[31:2];
  assign dmem.dmem_be_o    = be_q;
  assign dmem.dmem_wdata_o = wdata_q;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_cnt;

  assign tmo_hit = (state == ST_BUSY) && !dmem.dmem_ack_i && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tmo_cnt   <= '0;
      bus_err_o <= 1'b0;
    end else begin
      tmo_cnt   <= (state == ST_BUSY) ? tmo_cnt + 8'd1 : 8'd0;
      bus_err_o <= tmo_hit;
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign bus_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state        <= ST_IDLE;
      rd_q         <= '0;
      alu_q        <= '0;
      wb_sel_q     <= '0;
      pc_q         <= '0;
      is_load_q    <= 1'b0;
      f3_q         <= '0;
      we_q         <= 1'b0;
      be_q         <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      misaligned_o <= 1'b0;
    end else begin
      misaligned_o <= (state == ST_IDLE) && mem_op && al_misal;
      case (state)
        ST_IDLE: if (start) begin
          state     <= ST_BUSY;
          rd_q      <= rd_i;
          alu_q     <= alu_out_i;
          wb_sel_q  <= wb_sel_i;
          pc_q      <= pc_i;
          is_load_q <= is_load_i;
          f3_q      <= funct3_i;
          we_q      <= is_store_i;
          be_q      <= is_store_i ? al_be : 4'b1111;
          wdata_q   <= al_wdata;
        end
        ST_BUSY: begin
          if (dmem.dmem_ack_i) begin
            rdata_q <= is_load_q ? al_load : 32'h0;
            state   <= ST_DONE;
          end else if (tmo_hit) begin
            rdata_q <= 32'h0;
            state   <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stalled cycles push a bubble (rd/is_load cleared) while the rest holds.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      memwb_q <= '0;
    end else if (busywait_o) begin
      memwb_q.rd      <= '0;
      memwb_q.is_load <= 1'b0;
    end else if (state == ST_DONE) begin
      memwb_q <= '{rd: rd_q, alu_out: alu_q, rd_data: rdata_q,
                   wb_sel: wb_sel_q, pc: pc_q, is_load: is_load_q};
    end else begin
      memwb_q <= '{rd: rd_i, alu_out: alu_out_i, rd_data: 32'h0,
                   wb_sel: wb_sel_i, pc: pc_i, is_load: is_load_i};
    end
  end

  assign rd_mem_wb_o            = memwb_q.rd;
  assign alu_out_mem_wb_o       = memwb_q.alu_out;
  assign rd_data_mem_wb_o       = memwb_q.rd_data;
  assign wb_sel_mem_wb_o        = memwb_q.wb_sel;
  assign pc_mem_wb_o            = memwb_q.pc;
  assign is_load_instr_mem_wb_o = memwb_q.is_load;

endmodule

// File: tb/tb_memory_access_stage.sv
// Scoreboard bench for memory_access_stage: expected MEM/WB records queued at issue,
// compared when the stage completes; a small memory model answers requests.
module tb_memory_access_stage;
  import mem_pkg::*;

  localparam int TMO = 4;
`ifdef MEM_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] alu_out, rs2, pc;
  logic [2:0]  funct3;
  logic        is_load, is_store;
  logic [4:0]  rd;
  logic [1:0]  wb_sel;
  logic        busywait, misaligned, bus_err, is_load_wb;
  logic [4:0]  rd_wb;
  logic [31:0] alu_wb, rdata_wb, pc_wb;
  logic [1:0]  wb_sel_wb;

  dmem_if bus();

  memory_access_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .alu_out_i(alu_out), .rs2_i(rs2), .funct3_i(funct3),
    .is_load_i(is_load), .is_store_i(is_store),
    .rd_i(rd), .wb_sel_i(wb_sel), .pc_i(pc),
    .dmem(bus),
    .busywait_o(busywait),
    .rd_mem_wb_o(rd_wb), .alu_out_mem_wb_o(alu_wb), .rd_data_mem_wb_o(rdata_wb),
    .wb_sel_mem_wb_o(wb_sel_wb), .pc_mem_wb_o(pc_wb), .is_load_instr_mem_wb_o(is_load_wb),
    .misaligned_o(misaligned), .bus_err_o(bus_err)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] data;
    logic [1:0]  wb_sel;
    logic [31:0] pc;
    logic        is_load;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;

  // memory model: acks on BUSY cycle ack_cycle (0 = never), checks request stability
  int          ack_cycle = 1;
  int          req_cnt = 0;
  logic [31:0] rdata_next = '0;
  logic        mem_ack = 1'b0, extra_ack = 1'b0;
  logic [29:0] cap_addr;
  logic [3:0]  cap_be;
  logic        cap_we;
  logic [31:0] cap_wdata;
  assign bus.dmem_ack_i = mem_ack | extra_ack;

  always @(negedge clk) begin
    if (bus.dmem_req_o) begin
      req_cnt++;
      if (req_cnt == 1) begin
        cap_addr = bus.dmem_addr_o; cap_be = bus.dmem_be_o;
        cap_we = bus.dmem_we_o; cap_wdata = bus.dmem_wdata_o;
      end else begin
        chk("req_addr_stable", 32'(bus.dmem_addr_o), 32'(cap_addr));
        chk("req_be_stable", 32'(bus.dmem_be_o), 32'(cap_be));
        chk("req_wdata_stable", bus.dmem_wdata_o, cap_wdata);
      end
      bus.dmem_rdata_i = rdata_next;
      mem_ack = (ack_cycle != 0) && (req_cnt >= ack_cycle);
    end else begin
      mem_ack = 1'b0;
    end
  end

  int mis_cnt = 0, berr_cnt = 0;
  always @(negedge clk) begin
    if (misaligned) mis_cnt++;
    if (bus_err) berr_cnt++;
  end

  // MEM/WB monitor: an instruction completes on the edge after a cycle with busywait low
  logic active = 1'b0;
  logic pend = 1'b0;
  always @(negedge clk) begin
    if (pend) begin
      pend = 1'b0;
      if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else begin
        e_mon = sb.pop_front();
        chk("wb_rd", 32'(rd_wb), 32'(e_mon.rd));
        chk("wb_alu", alu_wb, e_mon.alu);
        chk("wb_rdata", rdata_wb, e_mon.data);
        chk("wb_sel", 32'(wb_sel_wb), 32'(e_mon.wb_sel));
        chk("wb_pc", pc_wb, e_mon.pc);
        chk("wb_is_load", 32'(is_load_wb), 32'(e_mon.is_load));
      end
    end
    if (active && rst_n && !busywait) pend = 1'b1;
  end

  task automatic drive_nop();
    is_load = 1'b0; is_store = 1'b0; rd = '0; alu_out = '0; rs2 = '0;
    funct3 = '0; wb_sel = '0; pc = '0;
  endtask

  int pc_seq = 0;

  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] rdat, input int ackc, input logic [4:0] rdn);
    logic [1:0]  off;
    logic        byte_w, half_w, word_w, mis, mem, tmo, done;
    logic [31:0] lane, exp_data, exp_wdata;
    logic [3:0]  exp_be;
    int          exp_busy, exp_req, busy, n;
    exp_t        e;
    off    = addr[1:0];
    byte_w = (f3[1:0] == 2'b00);
    half_w = (f3[1:0] == 2'b01);
    word_w = f3[1];
    mis    = (ld | st) && ((half_w && off[0]) || (word_w && off != 2'b00));
    mem    = (ld | st) && !mis;
    tmo    = mem && TMO_EN && (ackc == 0 || ackc > TMO);
    lane   = rdat >> (32'(off) * 8);
    exp_data = 32'h0;
    if (ld && mem && !tmo) begin
      if (byte_w)      exp_data = f3[2] ? {24'h0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      else if (half_w) exp_data = f3[2] ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      else             exp_data = rdat;
    end
    exp_be = 4'b1111;
    exp_wdata = data;
    if (st && byte_w) begin exp_be = 4'b0001 << off; exp_wdata = {4{data[7:0]}}; end
    if (st && half_w) begin exp_be = off[1] ? 4'b1100 : 4'b0011; exp_wdata = {2{data[15:0]}}; end
    exp_req  = mem ? (tmo ? TMO : ackc) : 0;
    exp_busy = mem ? exp_req + 1 : 0;

    @(posedge clk); #1;
    req_cnt = 0; mis_cnt = 0; berr_cnt = 0; ack_cycle = ackc; rdata_next = rdat;
    pc_seq++;
    is_load = ld; is_store = st; funct3 = f3; alu_out = addr; rs2 = data; rd = rdn;
    wb_sel = {ld, st}; pc = 32'h1000 + 32'(pc_seq) * 4;
    e.rd = rdn; e.alu = addr; e.data = exp_data; e.wb_sel = {ld, st}; e.pc = pc; e.is_load = ld;
    sb.push_back(e);
    active = 1'b1;

    busy = 0; n = 0; done = 1'b0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      if (busywait) begin
        busy++;
        chk("stall_bubble_rd", 32'(rd_wb), 32'd0);
        chk("stall_bubble_ld", 32'(is_load_wb), 32'd0);
      end else done = 1'b1;
    end
    if (!done) chk("completion_wait_expired", 32'd0, 32'd1);

    @(posedge clk); #1;
    drive_nop();
    active = 1'b0;
    @(negedge clk); #1;
    chk("busy_cycles", 32'(busy), 32'(exp_busy));
    chk("req_cycles", 32'(req_cnt), 32'(exp_req));
    chk("misaligned_pulses", 32'(mis_cnt), {31'h0, mis});
    chk("bus_err_pulses", 32'(berr_cnt), {31'h0, tmo});
    if (mem) begin
      chk("req_addr", 32'(cap_addr), 32'(addr[31:2]));
      chk("req_be", 32'(cap_be), 32'(exp_be));
      chk("req_we", 32'(cap_we), 32'(st));
      if (st) chk("req_wdata", cap_wdata, exp_wdata);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_nop();
    bus.dmem_rdata_i = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(bus.dmem_req_o), 32'd0);
    chk("rst_busywait", 32'(busywait), 32'd0);
    chk("rst_misaligned", 32'(misaligned), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_rd", 32'(rd_wb), 32'd0);
    chk("rst_rdata", rdata_wb, 32'd0);
    chk("rst_pc", pc_wb, 32'd0);
    rst_n = 1'b1;

    issue(1'b0, 1'b1, F3_SW,  32'h100, 32'hDEADBEEF, 32'h0,       1, 5'd3);
    issue(1'b1, 1'b0, F3_LB,  32'h203, 32'h0,        32'h80FFFFFF, 1, 5'd4);
    issue(1'b1, 1'b0, F3_LBU, 32'h203, 32'h0,        32'h80FFFFFF, 2, 5'd5);
    issue(1'b0, 1'b1, F3_SH,  32'h102, 32'h0000ABCD, 32'h0,       1, 5'd6);
    issue(1'b0, 1'b1, F3_SH,  32'h101, 32'h0000ABCD, 32'h0,       1, 5'd7);
    issue(1'b1, 1'b0, F3_LW,  32'h400, 32'h0,        32'hCAFEF00D, 5, 5'd8);
    issue(1'b1, 1'b0, F3_LH,  32'h202, 32'h0,        32'h80017FFF, 1, 5'd9);
    issue(1'b1, 1'b0, F3_LHU, 32'h202, 32'h0,        32'h80017FFF, 1, 5'd10);
    issue(1'b1, 1'b0, F3_LH,  32'h200, 32'h0,        32'h80017FFF, 1, 5'd11);
    issue(1'b0, 1'b1, F3_SB,  32'h003, 32'h0000005A, 32'h0,       3, 5'd12);
    issue(1'b0, 1'b0, 3'b000, 32'h1234, 32'h0,       32'h0,       1, 5'd13);
    issue(1'b1, 1'b0, 3'b011, 32'h010, 32'h0,        32'h12345678, 1, 5'd14);
    issue(1'b0, 1'b1, 3'b111, 32'h014, 32'h87654321, 32'h0,       2, 5'd15);
    issue(1'b1, 1'b0, F3_LW,  32'h102, 32'h0,        32'h11111111, 1, 5'd16);
`ifdef MEM_TIMEOUT_EN
    issue(1'b1, 1'b0, F3_LW,  32'h500, 32'h0,        32'hFFFFFFFF, 0, 5'd17);
`endif
    for (int i = 0; i < 10; i++) begin
      logic l;
      l = 1'($urandom_range(0, 1));
      issue(l, !l, 3'($urandom_range(0, 7)), $urandom & 32'hFFFF, $urandom, $urandom,
            int'($urandom_range(1, 3)), 5'($urandom_range(1, 31)));
    end

    // reset in the 2nd BUSY cycle, then a stray ack while IDLE
    @(posedge clk); #1;
    ack_cycle = 0; req_cnt = 0;
    is_load = 1'b1; funct3 = F3_LW; alu_out = 32'h300; rd = 5'd9; pc = 32'h2000; wb_sel = 2'b10;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive_nop();
    @(negedge clk);
    chk("rstbusy_req_before", 32'(bus.dmem_req_o), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("rstbusy_req", 32'(bus.dmem_req_o), 32'd0);
    chk("rstbusy_busywait", 32'(busywait), 32'd0);
    chk("rstbusy_rd", 32'(rd_wb), 32'd0);
    chk("rstbusy_rdata", rdata_wb, 32'd0);
    chk("rstbusy_alu", alu_wb, 32'd0);
    chk("rstbusy_pc", pc_wb, 32'd0);
    chk("rstbusy_is_load", 32'(is_load_wb), 32'd0);
    extra_ack = 1'b1;
    bus.dmem_rdata_i = 32'hFFFFFFFF;
    rst_n = 1'b1;
    @(negedge clk);
    extra_ack = 1'b0;
    chk("stray_ack_req", 32'(bus.dmem_req_o), 32'd0);
    chk("stray_ack_busywait", 32'(busywait), 32'd0);
    chk("stray_ack_rdata", rdata_wb, 32'd0);
    chk("stray_ack_rd", 32'(rd_wb), 32'd0);

    issue(1'b1, 1'b0, F3_LW, 32'h600, 32'h0, 32'hA5A5A5A5, 2, 5'd20);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_access_stage.md
MEMORY_ACCESS_STAGE -- requirements
Module: memory_access_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum BUSY cycles awaiting dmem_ack_i (only with MEM_TIMEOUT_EN).
REQ-002 SHALL have clk_i  in  1  single clock; all state changes on rising edge.
REQ-003 SHALL have rst_ni  in  1  reset, synchronous, active-low.
REQ-004 SHALL have alu_out_i  in  32  EX/MEM result, byte address for load/store.
REQ-005 SHALL have rs2_i  in  32  EX/MEM store data.
REQ-006 SHALL have funct3_i  in  3  load/store width and sign.
REQ-007 SHALL have is_load_i, is_store_i  in  1 each  EX/MEM access type, never both high.
REQ-008 SHALL have rd_i  in  5; wb_sel_i  in  2; pc_i  in  32  EX/MEM passthrough fields.
REQ-009 SHALL have dmem_req_o  out  1; dmem_we_o  out  1; dmem_addr_o  out  30 (word address [31:2]); dmem_be_o  out  4; dmem_wdata_o  out  32  data-memory request.
REQ-010 SHALL have dmem_rdata_i  in  32; dmem_ack_i  in  1  data-memory response.
REQ-011 SHALL have busywait_o  out  1  pipeline stall to IF/ID/EX.
REQ-012 SHALL have rd_mem_wb_o  5, alu_out_mem_wb_o  32, rd_data_mem_wb_o  32, wb_sel_mem_wb_o  2, pc_mem_wb_o  32, is_load_instr_mem_wb_o  1  outputs forming the MEM/WB register.
REQ-013 SHALL have misaligned_o  out  1 and bus_err_o  out  1  single-cycle fault pulses.

Function
REQ-014 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-015 IDLE with (is_load_i|is_store_i) and an aligned address: next BUSY, busywait_o=1 combinationally in the same cycle.
REQ-016 BUSY: dmem_req_o=1 with addr/we/be/wdata stable; busywait_o=1; on dmem_ack_i, capture the formatted read data, next DONE.
REQ-017 DONE: busywait_o=0, dmem_req_o=0; MEM/WB register loads; next IDLE. Minimum access latency is 3 cycles.
REQ-018 Non-memory instruction in IDLE: busywait_o=0; MEM/WB register loads in the same edge (1 cycle).
REQ-019 While busywait_o=1, MEM/WB register SHALL load a bubble: rd_mem_wb_o=0, is_load_instr_mem_wb_o=0; other fields hold.
REQ-020 Stores: SB be=4'b0001<<addr[1:0], byte replicated x4; SH be=4'b0011<<{addr[1],1'b0}, half replicated x2; SW be=4'b1111.
REQ-021 Loads: dmem_we_o=0, dmem_be_o=4'b1111. LB/LH sign-extend and LBU/LHU zero-extend the lane selected by addr[1:0]; LW passes the word unchanged.
REQ-022 Misaligned access (LH/SH/LHU addr[0]=1; LW/SW addr[1:0]!=0): no request issued; misaligned_o pulses 1 cycle; result 0; completes like a non-memory instruction.
REQ-023 Unused funct3 (011, 110, 111) SHALL be treated as LW/SW.
REQ-024 dmem_ack_i outside BUSY SHALL be ignored.
REQ-025 rd_data_mem_wb_o SHALL be 0 for stores and non-loads.

Reset
REQ-026 rst_ni=0 at any edge: state IDLE; all MEM/WB outputs 0; timeout counter 0; dmem_req_o, busywait_o, misaligned_o, bus_err_o 0 from the next cycle. An outstanding access is abandoned and a late ack is ignored.

Configuration
REQ-027 With MEM_TIMEOUT_EN defined, an 8-bit counter SHALL count BUSY cycles. When it reaches TIMEOUT_CYCLES without ack: go to DONE, pulse bus_err_o 1 cycle, force load data to 0, store has no further effect.
REQ-028 Without MEM_TIMEOUT_EN, BUSY SHALL wait indefinitely, bus_err_o SHALL be tied 0, and no counter is synthesized.

Structure
REQ-029 A shared package mem_pkg SHALL hold the funct3 load/store encodings, the FSM state encodings, and the default TIMEOUT_CYCLES.
REQ-030 A combinational sub-module load_store_aligner SHALL hold the byte-enable, store-replication and load-extension logic; the FSM and registers stay in memory_access_stage.

Verification
REQ-031 SW addr 0x100, rs2 0xDEADBEEF, ack in 1st BUSY cycle -> be=1111, addr=0x40, wdata=0xDEADBEEF, busywait high exactly 2 cycles.
REQ-032 LB addr 0x203 with rdata 0x80FFFFFF -> rd_data_mem_wb_o=0xFFFFFF80; the same access as LBU -> 0x00000080.
REQ-033 SH addr 0x102, rs2 0x0000ABCD -> be=1100, wdata=0xABCDABCD; SH addr 0x101 -> misaligned_o pulse, no dmem_req_o.
REQ-034 LW with ack delayed 5 cycles -> req held stable 5 cycles, rd_mem_wb_o=0 during the stall, then the real rd loads once.
REQ-035 rst_ni low in the 2nd BUSY cycle, ack arrives next cycle -> dmem_req_o=0, outputs 0, ack ignored.
REQ-036 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> bus_err_o pulse after 4 BUSY cycles, load result 0, FSM returns to IDLE.
